// File: rtl/i2s_data_output.sv
// ---------------------------------------------------------------------------
// i2s_data_output
//
// Transmit side of the I2S bridge. Samples arrive on a parallel valid/ready
// port, are buffered in a FIFO and shifted out MSB-first on sdata in
// standard I2S framing. bclk and lrclk are derived from clk.
//
// Handshake: a sample is accepted on every clk where in_valid && in_ready.
// in_ready depends only on the stored level (no combinational path from
// in_valid). A pop on the same clk does not free space for that push.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   enable       serial output run request
//   in_data      sample to push (DATA_W bits)
//   in_valid     push request
//   in_ready     FIFO can accept (level != FIFO_DEPTH)
//   bclk         bit clock, BCLK_DIV clk periods, high for the first half
//   lrclk        0 = left slot, 1 = right slot
//   sdata        serial data, changes only on bclk falling edges
//   fifo_level   number of stored samples
//   low_water    registered: level < FIFO_DEPTH/2 while enable
//   underrun     1-clk pulse when a slot starts with the FIFO empty
//   underrun_cnt saturating underrun counter (only with
//                DATA_OUTPUT_UNDERRUN_CNT_EN defined)
//
// Optional build macro: DATA_OUTPUT_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
module i2s_data_output #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          low_water,
    output logic                          underrun
`ifdef DATA_OUTPUT_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(SLOT_W);
    localparam int HALF  = BCLK_DIV / 2;
    localparam int PAD_W = SLOT_W - DATA_W;

    // FSM encoding; DRAIN holds the trailing I2S delay bit after the last
    // right slot before going back to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;

    assign in_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap mod FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Serial timing
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SLOT_W-1:0] shift_reg;
    logic              first_slot;
    logic              fall;
    logic              slot_start;
    logic              stop_req;
    logic              load;
    logic              underrun_set;

    assign div_next = (div_cnt == DIV_W'(BCLK_DIV - 1)) ? '0 : div_cnt + 1'b1;

    // bclk is registered as (div_cnt < HALF), so it drops on the edge that
    // moves the divider from HALF-1 to HALF.
    assign fall       = (state != ST_IDLE) && (div_cnt == DIV_W'(HALF - 1));
    assign slot_start = fall && (state == ST_RUN) && (bit_cnt == CNT_W'(SLOT_W - 1));

    // Stopping is only allowed at the end of a right slot (or before the
    // very first slot has started), so frames are never truncated.
    assign stop_req     = !enable && (first_slot || lrclk);
    assign load         = slot_start && !stop_req;
    assign pop          = load && (fifo_level != '0);
    assign underrun_set = load && (fifo_level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            first_slot <= 1'b0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            underrun   <= 1'b0;
            low_water  <= 1'b0;
        end else begin
            underrun  <= underrun_set;
            low_water <= enable && (fifo_level < LVL_W'(FIFO_DEPTH / 2));

            case (state)
                ST_IDLE: begin
                    div_cnt    <= '0;
                    bit_cnt    <= CNT_W'(SLOT_W - 1);
                    shift_reg  <= '0;
                    first_slot <= 1'b1;
                    bclk       <= 1'b0;
                    lrclk      <= 1'b0;
                    sdata      <= 1'b0;
                    if (enable) begin
                        state <= ST_RUN;
                        bclk  <= 1'b1;
                    end
                end

                ST_RUN, ST_DRAIN: begin
                    div_cnt <= div_next;
                    bclk    <= (div_next < DIV_W'(HALF));
                    if (fall) begin
                        // One-bclk I2S delay falls out of shifting after the
                        // load: bit k of a slot carries word[SLOT_W-k].
                        sdata     <= shift_reg[SLOT_W-1];
                        shift_reg <= {shift_reg[SLOT_W-2:0], 1'b0};
                        bit_cnt   <= (bit_cnt == CNT_W'(SLOT_W - 1)) ? '0 : bit_cnt + 1'b1;

                        if (state == ST_DRAIN) begin
                            state   <= ST_IDLE;
                            div_cnt <= '0;
                            lrclk   <= 1'b0;
                            sdata   <= 1'b0;
                        end else if (slot_start) begin
                            first_slot <= 1'b0;
                            if (stop_req) begin
                                if (first_slot) begin
                                    state   <= ST_IDLE;
                                    div_cnt <= '0;
                                    sdata   <= 1'b0;
                                end else begin
                                    state <= ST_DRAIN;
                                    lrclk <= 1'b0;
                                end
                            end else begin
                                // First slot after IDLE is left: lrclk stays 0.
                                if (!first_slot) begin
                                    lrclk <= ~lrclk;
                                end
                                shift_reg <= pop ? {rd_data, {PAD_W{1'b0}}} : '0;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DATA_OUTPUT_UNDERRUN_CNT_EN
    logic enable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                underrun_cnt <= '0;
            end else if (underrun_set && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
